// File: rtl/dds_dual_chan.sv
// -----------------------------------------------------------------------------
// dds_dual_chan
//
// Two-channel DDS waveform generator fed by the UART receiver's 16-bit command
// word. Byte i of the word sets channel i: bit 7 selects the waveform
// (0 sawtooth, 1 triangle) and bits 6:0 set the frequency. The phase increment
// is freq << INC_SHIFT.
//
// A captured command waits in a per-channel pending register. It moves to the
// active registers at the channel's next phase wrap, so a running waveform
// never changes in mid-period. An idle channel (increment 0) takes the command
// at once.
//
// Optional feature, macro DDS_FRAME_CHECK_EN:
//   defined   - uart_done is accepted only while stop_status is high
//   undefined - stop_status is ignored and every uart_done is accepted
//
// Parameters:
//   ACC_W     phase accumulator width (>= 16)
//   INC_SHIFT increment shift (INC_SHIFT + 7 <= ACC_W)
//
// Ports:
//   sys_clk      system clock
//   sys_rst_n    asynchronous reset, active low
//   uart_done    one-cycle strobe, uart_data is valid
//   uart_data    command word: [7] ch0 sel, [6:0] ch0 freq,
//                              [15] ch1 sel, [14:8] ch1 freq
//   stop_status  receiver saw a valid stop bit (level, sampled with uart_done)
//   cmd_pend     bit i high: channel i holds a command not yet applied
//   dac_data     [7:0] ch0 sample, [15:8] ch1 sample (registered)
// -----------------------------------------------------------------------------
module dds_dual_chan #(
  parameter int ACC_W     = 24,
  parameter int INC_SHIFT = 8
) (
  input  logic        sys_clk,
  input  logic        sys_rst_n,
  input  logic        uart_done,
  input  logic [15:0] uart_data,
  input  logic        stop_status,
  output logic [1:0]  cmd_pend,
  output logic [15:0] dac_data
);

  logic accept;

`ifdef DDS_FRAME_CHECK_EN
  // A word that arrived with a framing error is dropped without any effect.
  assign accept = uart_done & stop_status;
`else
  logic unused_stop_status;
  assign unused_stop_status = stop_status;
  assign accept             = uart_done;
`endif

  for (genvar i = 0; i < 2; i++) begin : g_chan
    logic             act_sel;
    logic [ACC_W-1:0] act_inc;
    logic             pend_sel;
    logic [ACC_W-1:0] pend_inc;
    logic             pend_flag;
    logic [ACC_W-1:0] acc;
    logic [7:0]       dac_q;

    logic             in_sel;
    logic [ACC_W-1:0] in_inc;
    logic [ACC_W:0]   sum;
    logic             apply;
    logic [7:0]       phase;
    logic [7:0]       sample;

    // Decode this channel's byte of the incoming command word.
    assign in_sel = uart_data[8*i+7];
    assign in_inc = {{(ACC_W-7){1'b0}}, uart_data[8*i +: 7]} << INC_SHIFT;

    // The extra top bit of the sum is the carry out of the accumulator, which
    // marks the phase wrap.
    assign sum   = {1'b0, acc} + {1'b0, act_inc};
    assign apply = (act_inc == '0) || sum[ACC_W];
    assign phase = acc[ACC_W-1 -: 8];

    // NOTE: every signal written in always_comb gets a default first, so no
    // path through the block leaves it unassigned and no latch is inferred.
    always_comb begin
      sample = phase;
      if (act_sel) begin
        // Triangle: ramp up over the first half period, down over the second.
        sample = phase[7] ? ~{phase[6:0], 1'b0} : {phase[6:0], 1'b0};
      end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        acc       <= '0;
        act_inc   <= '0;
        act_sel   <= 1'b0;
        pend_inc  <= '0;
        pend_sel  <= 1'b0;
        pend_flag <= 1'b0;
        dac_q     <= '0;
      end else begin
        // With a zero increment the accumulator holds its value, so a frozen
        // channel keeps presenting its last sample.
        acc   <= sum[ACC_W-1:0];
        dac_q <= sample;

        if (apply && accept) begin
          // A word arriving on the apply edge goes straight to the active
          // registers. Any older pending word is superseded.
          act_inc   <= in_inc;
          act_sel   <= in_sel;
          pend_flag <= 1'b0;
        end else if (apply && pend_flag) begin
          act_inc   <= pend_inc;
          act_sel   <= pend_sel;
          pend_flag <= 1'b0;
        end else if (accept) begin
          // A running channel parks the word until its wrap. A later word
          // overwrites an unapplied one.
          pend_inc  <= in_inc;
          pend_sel  <= in_sel;
          pend_flag <= 1'b1;
        end
      end
    end

    assign cmd_pend[i]         = pend_flag;
    assign dac_data[8*i +: 8] = dac_q;
  end

endmodule

// File: tb/tb_dds_dual_chan.sv
// -----------------------------------------------------------------------------
// tb_dds_dual_chan
//
// Self-checking bench for dds_dual_chan with ACC_W=24, INC_SHIFT=16. At these
// settings freq f advances the phase byte by f each cycle.
//
// The stimulus process drives inputs on the falling edge. It also queues the
// {cmd_pend, dac_data} values it expects after the following rising edge. A
// monitor samples the outputs 1 time unit after each rising edge. Whenever an
// expectation is waiting in the queue, the monitor pops it and compares.
//
// Let edge N be the rising edge that samples a command, and let k count edges
// after N. A channel that was idle before the command shows
//   dac = (f * (k-1)) mod 256   for edge N+k.
// -----------------------------------------------------------------------------
module tb_dds_dual_chan;

  localparam int ACC_W     = 24;
  localparam int INC_SHIFT = 16;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        uart_done = 1'b0;
  logic [15:0] uart_data = 16'h0000;
  logic        stop_status = 1'b1;
  logic [1:0]  cmd_pend;
  logic [15:0] dac_data;

  dds_dual_chan #(
    .ACC_W     (ACC_W),
    .INC_SHIFT (INC_SHIFT)
  ) dut (
    .sys_clk     (sys_clk),
    .sys_rst_n   (sys_rst_n),
    .uart_done   (uart_done),
    .uart_data   (uart_data),
    .stop_status (stop_status),
    .cmd_pend    (cmd_pend),
    .dac_data    (dac_data)
  );

  always #10 sys_clk = ~sys_clk;

  typedef struct {
    string       tag;
    logic [1:0]  pend;
    logic [15:0] dac;
  } exp_t;

  exp_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, req);
  endtask

  // Expected triangle output for phase byte p.
  function automatic logic [7:0] tri_wave(input int p);
    int q;
    q = p % 256;
    return (q < 128) ? 8'(2 * q) : 8'(255 - 2 * (q - 128));
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after that edge.
  task automatic cyc(input logic done, input logic [15:0] data, input logic stop,
                     input logic [1:0] ep, input logic [15:0] ed, input string tag);
    exp_t e;
    @(negedge sys_clk);
    uart_done   = done;
    uart_data   = data;
    stop_status = stop;
    e.tag  = tag;
    e.pend = ep;
    e.dac  = ed;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge sys_clk);
    sys_rst_n   = 1'b0;
    uart_done   = 1'b0;
    uart_data   = 16'h0000;
    stop_status = 1'b1;
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    cyc(1'b0, 16'h0000, 1'b1, 2'b00, 16'h0000, "reset_state");
  endtask

  // Monitor: one comparison pair per queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge sys_clk);
      #1;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check({e.tag, "_dac"},  32'(dac_data), 32'(e.dac));
        check({e.tag, "_pend"}, 32'(cmd_pend), 32'(e.pend));
      end
    end
  end

  // Watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

  initial begin
    logic [1:0]  ep;
    logic [15:0] ed;
    logic        dn;
    logic [15:0] dt;

    // 1: ch0 sawtooth freq 1, including the 255 -> 0 wrap; ch1 stays 0.
    do_reset();
    cyc(1'b1, 16'h0001, 1'b1, 2'b00, 16'h0000, "s1_cmd");
    for (int k = 1; k <= 260; k++)
      cyc(1'b0, 16'h0000, 1'b1, 2'b00, {8'h00, 8'((k - 1) % 256)},
          $sformatf("s1_k%0d", k));

    // 2: ch1 triangle freq 1 over a full period and beyond; ch0 stays 0.
    do_reset();
    cyc(1'b1, 16'h8100, 1'b1, 2'b00, 16'h0000, "s2_cmd");
    for (int k = 1; k <= 258; k++)
      cyc(1'b0, 16'h0000, 1'b1, 2'b00, {tri_wave(k - 1), 8'h00},
          $sformatf("s2_k%0d", k));

    // 3: retune a running ch0 to freq 4 in mid-period; applied at wrap edge N+256.
    do_reset();
    cyc(1'b1, 16'h0001, 1'b1, 2'b00, 16'h0000, "s3_cmd");
    for (int k = 1; k <= 330; k++) begin
      dn = (k == 100);
      dt = dn ? 16'h0004 : 16'h0000;
      ep = (k >= 100 && k <= 255) ? 2'b01 : 2'b00;
      ed = (k <= 256) ? {8'h00, 8'(k - 1)} : {8'h00, 8'((4 * (k - 257)) % 256)};
      cyc(dn, dt, 1'b1, ep, ed, $sformatf("s3_k%0d", k));
    end

    // 4: freq 2 then freq 3 before the wrap; only freq 3 is applied.
    do_reset();
    cyc(1'b1, 16'h0001, 1'b1, 2'b00, 16'h0000, "s4_cmd");
    for (int k = 1; k <= 280; k++) begin
      dn = (k == 50) || (k == 60);
      dt = (k == 50) ? 16'h0002 : (k == 60) ? 16'h0003 : 16'h0000;
      ep = (k >= 50 && k <= 255) ? 2'b01 : 2'b00;
      ed = (k <= 256) ? {8'h00, 8'(k - 1)} : {8'h00, 8'((3 * (k - 257)) % 256)};
      cyc(dn, dt, 1'b1, ep, ed, $sformatf("s4_k%0d", k));
    end

    // 5: command on the wrap edge itself is applied at once; cmd_pend stays 0.
    do_reset();
    cyc(1'b1, 16'h0001, 1'b1, 2'b00, 16'h0000, "s5_cmd");
    for (int k = 1; k <= 270; k++) begin
      dn = (k == 256);
      dt = dn ? 16'h0005 : 16'h0000;
      ed = (k <= 256) ? {8'h00, 8'(k - 1)} : {8'h00, 8'((5 * (k - 257)) % 256)};
      cyc(dn, dt, 1'b1, 2'b00, ed, $sformatf("s5_k%0d", k));
    end

    // 6: word with a bad stop bit; dropped only when frame checking is built in.
    do_reset();
    cyc(1'b1, 16'h0005, 1'b0, 2'b00, 16'h0000, "s6_cmd");
    for (int k = 1; k <= 12; k++) begin
`ifdef DDS_FRAME_CHECK_EN
      ed = 16'h0000;
`else
      ed = {8'h00, 8'(5 * (k - 1))};
`endif
      cyc(1'b0, 16'h0000, 1'b1, 2'b00, ed, $sformatf("s6_k%0d", k));
    end

    // 7: asynchronous reset mid-run with a command pending.
    do_reset();
    cyc(1'b1, 16'h0001, 1'b1, 2'b00, 16'h0000, "s7_cmd");
    for (int k = 1; k <= 20; k++) begin
      dn = (k == 10);
      dt = dn ? 16'h0004 : 16'h0000;
      ep = (k >= 10) ? 2'b01 : 2'b00;
      cyc(dn, dt, 1'b1, ep, {8'h00, 8'(k - 1)}, $sformatf("s7_k%0d", k));
    end
    @(negedge sys_clk);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check("rst_async_dac",  32'(dac_data), 32'h0);
    check("rst_async_pend", 32'(cmd_pend), 32'h0);
    repeat (2) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    for (int k = 1; k <= 5; k++)
      cyc(1'b0, 16'h0000, 1'b1, 2'b00, 16'h0000, $sformatf("s7_post_k%0d", k));

    repeat (2) @(negedge sys_clk);
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
